// File: rtl/com_pkg.sv
// Shared definitions for the console frame transmitter: sync bytes, packet type
// codes and the transmitter state encoding.
package com_pkg;

  localparam logic [7:0] HEAD0_DEFAULT = 8'h55;
  localparam logic [7:0] HEAD1_DEFAULT = 8'hAA;

  // Packet type codes, shared with the console controller
  localparam logic [3:0] BAG_DLINK = 4'h8;
  localparam logic [3:0] BAG_DTYPE = 4'h9;
  localparam logic [3:0] BAG_DTEMP = 4'hA;
  localparam logic [3:0] BAG_DATA0 = 4'hD;
  localparam logic [3:0] BAG_DATA1 = 4'hE;

  typedef enum logic [3:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StType,
    StLenH,
    StLenL,
    StRaddr,
    StRload,
    StData,
    StCsum,
    StDone
  } send_state_e;

  // Zero-extend a nibble into a frame byte
  function automatic logic [7:0] nib_byte(input logic [3:0] nib);
    return {4'h0, nib};
  endfunction

endpackage

// File: rtl/com_send_if.sv
// Byte stream towards the host link sink: valid/ready with held data.
interface com_send_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/com_send.sv
// Frame transmitter: on a console send request, emits
// HEAD0 HEAD1 type lenH lenL payload... checksum, reading the payload from the
// shared data RAM, then holds fd_send until the request is withdrawn.
module com_send
  import com_pkg::*;
#(
  parameter logic [7:0] HEAD0 = HEAD0_DEFAULT,
  parameter logic [7:0] HEAD1 = HEAD1_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_send,
  output logic        fd_send,
  input  logic [3:0]  send_btype,
  input  logic [11:0] ram_addr_init,
  input  logic [11:0] ram_dlen,
  output logic [11:0] ram_addr,
  input  logic [7:0]  ram_rxd,
  com_send_if.master  tx
);

  send_state_e state_q, state_d;
  logic [3:0]  btype_q, btype_d;
  logic [11:0] addr_q, addr_d;         // payload start address latched at frame start
  logic [11:0] rem_q, rem_d;           // payload bytes not yet transferred
  logic [7:0]  csum_q, csum_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        fd_send_q, fd_send_d;
  logic        xfer;

  assign xfer = tx_valid_q & tx.tx_ready;

  // Next-state, checksum and registered-output computation
  always_comb begin
    state_d    = state_q;
    btype_d    = btype_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    csum_d     = csum_q;
    ram_addr_d = ram_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    fd_send_d  = fd_send_q;

    // Checksum covers type through last payload byte; headers are skipped
    if (state_q == StIdle) begin
      csum_d = '0;
    end else if (xfer && (state_q inside {StType, StLenH, StLenL, StData})) begin
      csum_d = csum_q ^ tx_data_q;
    end

    unique case (state_q)
      StIdle: begin
        if (fs_send) begin
          btype_d    = send_btype;
          addr_d     = ram_addr_init;
          rem_d      = ram_dlen;
          tx_data_d  = HEAD0;
          tx_valid_d = 1'b1;
          state_d    = StHdr0;
        end
      end
      StHdr0: begin
        if (xfer) begin
          tx_data_d = HEAD1;
          state_d   = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          tx_data_d = nib_byte(btype_q);
          state_d   = StType;
        end
      end
      StType: begin
        if (xfer) begin
          tx_data_d = nib_byte(rem_q[11:8]);
          state_d   = StLenH;
        end
      end
      StLenH: begin
        if (xfer) begin
          tx_data_d = rem_q[7:0];
          state_d   = StLenL;
        end
      end
      StLenL: begin
        if (xfer) begin
          if (rem_q != 12'd0) begin
            tx_valid_d = 1'b0;
            ram_addr_d = addr_q;
            state_d    = StRaddr;
          end else begin
            // Fold in the byte being transferred now, as the accumulator lags by one
            tx_data_d = csum_q ^ tx_data_q;
            state_d   = StCsum;
          end
        end
      end
      StRaddr: begin
        state_d = StRload;
      end
      StRload: begin
        tx_data_d  = ram_rxd;
        tx_valid_d = 1'b1;
        state_d    = StData;
      end
      StData: begin
        if (xfer) begin
          rem_d = rem_q - 12'd1;
          if (rem_q == 12'd1) begin
            tx_data_d = csum_q ^ tx_data_q;
            state_d   = StCsum;
          end else begin
            tx_valid_d = 1'b0;
            ram_addr_d = ram_addr_q + 12'd1;
            state_d    = StRaddr;
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          fd_send_d  = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (!fs_send) begin
          fd_send_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        fd_send_d  = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      btype_q    <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      csum_q     <= '0;
      ram_addr_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      fd_send_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      btype_q    <= btype_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      csum_q     <= csum_d;
      ram_addr_q <= ram_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      fd_send_q  <= fd_send_d;
    end
  end

  assign fd_send     = fd_send_q;
  assign ram_addr    = ram_addr_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_com_send.sv
// Directed bench for com_send: frame contents, RAM address order, handshake
// timing, backpressure hold, address wrap, reset abort and early request drop.
module tb_com_send;
  import com_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs_send;
  logic        fd_send;
  logic [3:0]  send_btype;
  logic [11:0] ram_addr_init;
  logic [11:0] ram_dlen;
  logic [11:0] ram_addr;
  logic [7:0]  ram_rxd;

  com_send_if bus ();

  com_send dut (
    .clk           (clk),
    .rst           (rst),
    .fs_send       (fs_send),
    .fd_send       (fd_send),
    .send_btype    (send_btype),
    .ram_addr_init (ram_addr_init),
    .ram_dlen      (ram_dlen),
    .ram_addr      (ram_addr),
    .ram_rxd       (ram_rxd),
    .tx            (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data valid one cycle after the address
  logic [7:0] mem [4096];
  always @(posedge clk) ram_rxd <= mem[ram_addr];

  int errors = 0;
  int checks = 0;

  logic [7:0]  got_q[$];
  logic [11:0] alog_q[$];
  int fd_hi, fd_first, v_first, stalls;

  // Drive one request and collect everything until fd_send falls again
  task automatic run_frame(input logic [3:0] bt, input logic [11:0] ad, input logic [11:0] dl,
                           input bit rnd, input bit drop);
    int edges;
    bit done, stall_pend;
    logic [7:0] prev_data;
    logic [11:0] last_addr;
    got_q.delete();
    alog_q.delete();
    fd_hi = 0; fd_first = -1; v_first = -1; stalls = 0;
    done = 0; stall_pend = 0; edges = 0; prev_data = '0;
    @(posedge clk); #1;
    fs_send = 1'b1; send_btype = bt; ram_addr_init = ad; ram_dlen = dl;
    bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    last_addr = ram_addr;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (stall_pend) begin
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: tx_valid=%b tx_data=%h, required valid=1 data=%h",
                   bus.tx_valid, bus.tx_data, prev_data);
        end
      end
      stall_pend = bus.tx_valid && !bus.tx_ready;
      if (stall_pend) stalls++;
      prev_data = bus.tx_data;
      if (bus.tx_valid === 1'b1 && v_first < 0) v_first = edges;
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (ram_addr !== last_addr) begin
        alog_q.push_back(ram_addr);
        last_addr = ram_addr;
      end
      if (fd_send) begin
        fd_hi++;
        if (fd_first < 0) fd_first = edges;
      end
      if (fd_first >= 0 && !fd_send) begin
        done = 1;
      end else begin
        @(posedge clk); edges++; #1;
        if (edges == 1) begin
          // Mid-frame input changes must be ignored
          send_btype = ~bt; ram_addr_init = ~ad; ram_dlen = ~dl;
        end
        bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (drop && got_q.size() >= 2) fs_send = 1'b0;
        if (!drop && fd_hi >= 3) fs_send = 1'b0;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL frame_timeout: fd_send never completed, required a full handshake");
      fs_send = 1'b0;
    end
    bus.tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; fs_send = 1'b0; send_btype = '0; ram_addr_init = '0; ram_dlen = '0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fd_send !== 1'b0) begin errors++; $display("FAIL reset_fd_send: got %b, required 0", fd_send); end
    checks++;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b, required 0", bus.tx_valid); end
    checks++;
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, required 00", bus.tx_data); end
    checks++;
    if (ram_addr !== 12'h000) begin errors++; $display("FAIL reset_ram_addr: got %h, required 000", ram_addr); end
  endtask

  task automatic test_dlink();
    logic [7:0] exp_b[$];
    logic [11:0] exp_a[$];
    exp_b = '{8'h55, 8'hAA, 8'h08, 8'h00, 8'h02, 8'h12, 8'h34, 8'h2C};
    exp_a = '{12'hFCC, 12'hFCD};
    run_frame(BAG_DLINK, 12'hFCC, 12'd2, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != exp_b.size()) begin errors++; $display("FAIL dlink_len: got %0d bytes, required %0d", got_q.size(), exp_b.size()); end
    foreach (exp_b[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL dlink_byte%0d: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++;
    if (alog_q.size() != 2 || alog_q[0] !== exp_a[0] || alog_q[1] !== exp_a[1]) begin
      errors++; $display("FAIL dlink_addr: got %p, required %p", alog_q, exp_a);
    end
    checks++;
    if (v_first != 1) begin errors++; $display("FAIL dlink_head_latency: got %0d, required 1", v_first); end
    checks++;
    if (fd_first != 13) begin errors++; $display("FAIL dlink_fd_latency: got %0d, required 13", fd_first); end
    checks++;
    if (fd_hi != 4) begin errors++; $display("FAIL dlink_fd_hold: got %0d cycles, required 4", fd_hi); end
  endtask

  task automatic test_empty();
    logic [7:0] exp_b[$];
    exp_b = '{8'h55, 8'hAA, 8'h0D, 8'h00, 8'h00, 8'h0D};
    run_frame(BAG_DATA0, 12'h123, 12'd0, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != exp_b.size()) begin errors++; $display("FAIL empty_len: got %0d bytes, required %0d", got_q.size(), exp_b.size()); end
    foreach (exp_b[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL empty_byte%0d: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++;
    if (alog_q.size() != 0) begin errors++; $display("FAIL empty_addr: got %0d address changes, required 0", alog_q.size()); end
    checks++;
    if (fd_first != 7) begin errors++; $display("FAIL empty_fd_latency: got %0d, required 7", fd_first); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b[$];
    exp_b = '{8'h55, 8'hAA, 8'h08, 8'h00, 8'h02, 8'h12, 8'h34, 8'h2C};
    run_frame(BAG_DLINK, 12'hFCC, 12'd2, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != exp_b.size()) begin errors++; $display("FAIL bp_len: got %0d bytes, required %0d", got_q.size(), exp_b.size()); end
    foreach (exp_b[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL bp_byte%0d: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++;
    if (stalls == 0) begin errors++; $display("FAIL bp_stalls: got 0 stalled cycles, required at least 1"); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b[$];
    logic [11:0] exp_a[$];
    exp_b = '{8'h55, 8'hAA, 8'h0B, 8'h00, 8'h03, 8'hA5, 8'h3C, 8'hF0, 8'h61};
    exp_a = '{12'hFFF, 12'h000, 12'h001};
    run_frame(4'hB, 12'hFFF, 12'd3, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != exp_b.size()) begin errors++; $display("FAIL wrap_len: got %0d bytes, required %0d", got_q.size(), exp_b.size()); end
    foreach (exp_b[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL wrap_byte%0d: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++;
    if (alog_q.size() != 3 || alog_q[0] !== exp_a[0] || alog_q[1] !== exp_a[1] || alog_q[2] !== exp_a[2]) begin
      errors++; $display("FAIL wrap_addr: got %p, required %p", alog_q, exp_a);
    end
  endtask

  task automatic test_early_drop();
    logic [7:0] exp_b[$];
    exp_b = '{8'h55, 8'hAA, 8'h09, 8'h00, 8'h01, 8'h5A, 8'h52};
    run_frame(BAG_DTYPE, 12'h010, 12'd1, 1'b0, 1'b1);
    checks++;
    if (got_q.size() != exp_b.size()) begin errors++; $display("FAIL drop_len: got %0d bytes, required %0d", got_q.size(), exp_b.size()); end
    foreach (exp_b[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL drop_byte%0d: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++;
    if (fd_hi != 1) begin errors++; $display("FAIL drop_fd_pulse: got %0d cycles, required 1", fd_hi); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b[$];
    exp_b = '{8'h55, 8'hAA, 8'h0A, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h4A};
    @(posedge clk); #1;
    fs_send = 1'b1; send_btype = BAG_DTEMP; ram_addr_init = 12'h100; ram_dlen = 12'd4;
    bus.tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h11) begin
      errors++; $display("FAIL rstmid_in_data: valid=%b data=%h, required valid=1 data=11", bus.tx_valid, bus.tx_data);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0 || fd_send !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: valid=%b fd_send=%b, required 0 0", bus.tx_valid, fd_send);
    end
    fs_send = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    run_frame(BAG_DTEMP, 12'h100, 12'd4, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != exp_b.size()) begin errors++; $display("FAIL rstmid_len: got %0d bytes, required %0d", got_q.size(), exp_b.size()); end
    foreach (exp_b[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL rstmid_byte%0d: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'hFCC] = 8'h12; mem[12'hFCD] = 8'h34;
    mem[12'hFFF] = 8'hA5; mem[12'h000] = 8'h3C; mem[12'h001] = 8'hF0;
    mem[12'h010] = 8'h5A;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    test_reset();
    test_dlink();
    test_empty();
    test_backpressure();
    test_wrap();
    test_early_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/com_send.md
# com_send

Frame transmitter between the console controller and the host link byte sink. When the console requests a send, this block latches the packet type, RAM start address and payload length. It emits one framed packet: header, type, length, payload bytes read from the shared data RAM, and checksum. It then reports completion with a level handshake that the console's `*_SEND` states wait on.

## Interface
Parameters:
- `HEAD0`, default 8'h55: first sync byte.
- `HEAD1`, default 8'hAA: second sync byte.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-low.
- `fs_send` in 1: send request level from the console. Held high until `fd_send` is seen.
- `fd_send` out 1: send done level.
- `send_btype` in 4: packet type. Sampled at frame start.
- `ram_addr_init` in 12: first payload RAM address. Sampled at frame start.
- `ram_dlen` in 12: payload byte count, 0..4095. Sampled at frame start.
- `ram_addr` out 12: RAM read address.
- `ram_rxd` in 8: RAM read data. Valid one cycle after `ram_addr`.
- `tx_data` out 8: byte to sink.
- `tx_valid` out 1: byte valid.
- `tx_ready` in 1: sink accepts byte. A transfer happens when `tx_valid && tx_ready`.

## Operation
- Frame byte order:
  - `HEAD0`, `HEAD1`
  - `{4'h0, btype}`
  - `{4'h0, dlen[11:8]}`, `dlen[7:0]`
  - `dlen` payload bytes from RAM[addr], RAM[addr+1], …
  - checksum
- Checksum: XOR of every transferred byte from the type byte through the last payload byte, inclusive. Headers are excluded. The accumulator clears at frame start.
- RAM address increments modulo 4096; address 12'hFFF wraps to 12'h000.
- State machine:
  - `IDLE` → on `fs_send`, latch `btype`/`addr`/`dlen` and go to `HDR0`.
  - `HDR0` → `HDR1` → `TYPE` → `LENH` → `LENL`. Each advances on transfer.
  - `LENL` → on transfer, `RADDR` if `dlen != 0`, else `CSUM`.
  - `RADDR`: drives `ram_addr`. Always → `RLOAD`.
  - `RLOAD`: captures `ram_rxd` into `tx_data`. Always → `DATA`.
  - `DATA` → on transfer, decrement remaining count. Go to `RADDR` with address+1 if more bytes remain, else `CSUM`.
  - `CSUM` → on transfer, `DONE`.
  - `DONE`: `fd_send` = 1. When `fs_send` = 0, go to `IDLE`.
- `tx_valid` is 1 only in `HDR0`/`HDR1`/`TYPE`/`LENH`/`LENL`/`DATA`/`CSUM`. While `tx_valid` is 1 and `tx_ready` is 0, `tx_data` holds stable.
- Inputs are ignored outside `IDLE`. Changes to `send_btype`/`ram_addr_init`/`ram_dlen` mid-frame have no effect.
- If `fs_send` drops before `DONE`, the frame still completes. `DONE` then sees `fs_send` = 0 and `fd_send` is high for exactly one cycle.
- A new frame cannot start in the cycle `DONE` → `IDLE`. The earliest restart is the next cycle.
- Reset values: `fd_send` 0, `tx_valid` 0, `tx_data` 8'h00, `ram_addr` 12'h000, state `IDLE`, checksum 0.
- Reset asserted mid-frame aborts immediately; the partial frame is not resumed.

## Timing
- All outputs are registered.
- `fs_send` first high at edge N → `tx_valid` = 1 with `HEAD0` after edge N+1.
- Header/length bytes: one byte per cycle with `tx_ready` held high.
- Payload: 3 cycles per byte minimum (`RADDR`, `RLOAD`, `DATA`).
- `ram_addr` is valid throughout `RADDR`; `ram_rxd` is sampled at the end of `RLOAD`.
- `fd_send` rises the cycle after the checksum transfer. It stays high while `fs_send` = 1 and falls the cycle after `fs_send` is seen low.
- Minimum frame with `dlen` = 0: 6 transfers, `fd_send` at cycle 7 after the request.

## Structure
- Package `com_pkg`:
  - `HEAD0`/`HEAD1` defaults
  - `BAG_*` type codes (DLINK 4'h8, DTYPE 4'h9, DTEMP 4'hA, DATA0 4'hD, DATA1 4'hE), shared with the console
  - state encoding of this block
- Single module, no sub-module. The checksum is a 3-line accumulator inline.

## Test plan
- DLINK frame: btype 8, addr 12'hFCC, dlen 2, RAM[FCC] = 12, RAM[FCD] = 34, `tx_ready` = 1.
  - Required bytes: 55 AA 08 00 02 12 34 2C.
  - `ram_addr` sequence FCC, FCD.
  - `fd_send` high until `fs_send` low.
- Empty payload: btype D, dlen 0 → 55 AA 0D 00 00 0D. No `ram_addr` change. `fd_send` 7 cycles after the request.
- Backpressure: same as the DLINK case with `tx_ready` random 50%. The byte stream is identical, and `tx_data` is stable on every stalled cycle.
- Address wrap: addr 12'hFFF, dlen 3.
  - Required reads: FFF, 000, 001.
  - Checksum = 0B ^ 00 ^ 03 ^ payload.
- Reset mid-payload: assert `rst` = 0 during `DATA`. Required: `tx_valid`/`fd_send` 0 at once, and a following request produces a complete fresh frame.
- Early `fs_send` drop: deassert `fs_send` after `HEAD1`. Required: the frame completes and `fd_send` pulses for exactly 1 cycle.
